// File: rtl/analyzer_pkg.sv
// Shared types and constants for the SUMP command path.
package analyzer_pkg;

  typedef enum logic [1:0] {CD_IDLE, CD_PAYLOAD, CD_COMMIT} cmd_dec_state_t;

  localparam int unsigned LONG_CMD_BIT      = 7;
  localparam int unsigned CMD_PAYLOAD_BYTES = 4;
  localparam int unsigned BYTE_CNT_W        = $clog2(CMD_PAYLOAD_BYTES);

  localparam logic [7:0] OP_RESET      = 8'h00;
  localparam logic [7:0] OP_ARM        = 8'h01;
  localparam logic [7:0] OP_QUERY_ID   = 8'h02;
  localparam logic [7:0] OP_QUERY_META = 8'h04;
  localparam logic [7:0] OP_SET_DIV    = 8'h80;
  localparam logic [7:0] OP_SET_COUNT  = 8'h81;
  localparam logic [7:0] OP_TRIG_MASK  = 8'hC0;
  localparam logic [7:0] OP_TRIG_VAL   = 8'hC1;

  typedef struct packed {
    logic [7:0]  opcode;
    logic [31:0] payload;
  } sump_cmd_t;

  function automatic logic is_long_cmd(input logic [7:0] b);
    return b[LONG_CMD_BIT];
  endfunction

endpackage

// File: rtl/cmd_timeout_timer.sv
// Inter-byte idle counter; expired stays high once LIMIT idle cycles have elapsed.
module cmd_timeout_timer #(
  parameter int unsigned LIMIT = 16,
  parameter int unsigned W     = $clog2(LIMIT + 1)
) (
  input  logic clock,
  input  logic ext_reset_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [W-1:0] count;
  logic [W-1:0] count_next;

  // Saturate at LIMIT so a long stall cannot wrap back below it.
  always_comb begin
    count_next = count;
    if (clr) begin
      count_next = '0;
    end else if (en && (count != W'(LIMIT))) begin
      count_next = count + W'(1);
    end
  end

  always_ff @(posedge clock or negedge ext_reset_n) begin
    if (!ext_reset_n) begin
      count   <= '0;
      expired <= 1'b0;
    end else begin
      count   <= count_next;
      expired <= (count_next == W'(LIMIT));
    end
  end

endmodule

// File: rtl/command_decoder.sv
// Assembles SUMP short/long commands from the UART byte stream.
// Optional inter-byte timeout is enabled by defining CMD_TIMEOUT_EN.
module command_decoder
  import analyzer_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 100_000,
  parameter int unsigned TIMEOUT_W      = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic        clock,
  input  logic        ext_reset_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  input  logic        rx_error,
  output logic [7:0]  opcode,
  output logic [31:0] command,
  output logic        cmd_recv_rx,
  output logic        cmd_busy,
  output logic        cmd_error
);

  cmd_dec_state_t         state;
  sump_cmd_t              shadow;
  logic [BYTE_CNT_W-1:0]  byte_cnt;
  logic                   byte_accepted;
  logic                   timeout_expired;

  // rx_error always wins over a coincident byte.
  assign byte_accepted = rx_valid && !rx_error;

`ifdef CMD_TIMEOUT_EN
  cmd_timeout_timer #(
    .LIMIT (TIMEOUT_CYCLES),
    .W     (TIMEOUT_W)
  ) u_timeout (
    .clock       (clock),
    .ext_reset_n (ext_reset_n),
    .clr         (byte_accepted),
    .en          (state == CD_PAYLOAD),
    .expired     (timeout_expired)
  );
`else
  logic [TIMEOUT_W-1:0] timeout_unused;
  assign timeout_unused  = TIMEOUT_W'(TIMEOUT_CYCLES);
  assign timeout_expired = 1'b0;
`endif

  always_ff @(posedge clock or negedge ext_reset_n) begin
    if (!ext_reset_n) begin
      state       <= CD_IDLE;
      shadow      <= '0;
      byte_cnt    <= '0;
      opcode      <= '0;
      command     <= '0;
      cmd_recv_rx <= 1'b0;
      cmd_busy    <= 1'b0;
      cmd_error   <= 1'b0;
    end else begin
      cmd_recv_rx <= 1'b0;
      cmd_error   <= 1'b0;
      case (state)
        // COMMIT publishes the shadow and also accepts a new opcode like IDLE.
        CD_IDLE, CD_COMMIT: begin
          if (state == CD_COMMIT) begin
            opcode      <= shadow.opcode;
            command     <= shadow.payload;
            cmd_recv_rx <= 1'b1;
          end
          if (byte_accepted) begin
            shadow.opcode  <= rx_data;
            shadow.payload <= '0;
            byte_cnt       <= '0;
            if (is_long_cmd(rx_data)) begin
              state    <= CD_PAYLOAD;
              cmd_busy <= 1'b1;
            end else begin
              state    <= CD_COMMIT;
              cmd_busy <= 1'b0;
            end
          end else begin
            state    <= CD_IDLE;
            cmd_busy <= 1'b0;
          end
        end

        CD_PAYLOAD: begin
          if (rx_error) begin
            shadow    <= '0;
            cmd_error <= 1'b1;
            cmd_busy  <= 1'b0;
            state     <= CD_IDLE;
          end else if (rx_valid) begin
            shadow.payload[{byte_cnt, 3'b000} +: 8] <= rx_data;
            byte_cnt <= byte_cnt + BYTE_CNT_W'(1);
            if (byte_cnt == BYTE_CNT_W'(CMD_PAYLOAD_BYTES - 1)) begin
              state    <= CD_COMMIT;
              cmd_busy <= 1'b0;
            end
          end else if (timeout_expired) begin
            shadow    <= '0;
            cmd_error <= 1'b1;
            cmd_busy  <= 1'b0;
            state     <= CD_IDLE;
          end
        end

        default: begin
          state    <= CD_IDLE;
          cmd_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_command_decoder.sv
// Self-checking bench for command_decoder: vector table + strobe scoreboard.
`timescale 1ns/1ps
module tb_command_decoder;
  import analyzer_pkg::*;

  logic        clock = 1'b0;
  logic        ext_reset_n;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_error;
  logic [7:0]  opcode;
  logic [31:0] command;
  logic        cmd_recv_rx;
  logic        cmd_busy;
  logic        cmd_error;

  command_decoder #(.TIMEOUT_CYCLES(16)) dut (
    .clock       (clock),
    .ext_reset_n (ext_reset_n),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_error    (rx_error),
    .opcode      (opcode),
    .command     (command),
    .cmd_recv_rx (cmd_recv_rx),
    .cmd_busy    (cmd_busy),
    .cmd_error   (cmd_error)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [7:0]  opcode;
    logic [31:0] payload;
  } exp_t;

  typedef struct {
    int unsigned nbytes;
    logic [39:0] bytes;
    int unsigned gap;
    bit          abort;
    bit          abort_valid;
    bit          exp_strobe;
    int          exp_err;
    logic [7:0]  exp_op;
    logic [31:0] exp_cmd;
  } vec_t;

  exp_t        exp_q[$];
  int          vectors = 0;
  int          miscompares = 0;
  int          strobes = 0;
  int          err_count = 0;
  logic [7:0]  prev_op = '0;
  logic [31:0] prev_cmd = '0;
  logic [7:0]  last_op = '0;
  logic [31:0] last_cmd = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clock); #1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clock); #1;
    end
  endtask

  task automatic expect_cmd(input logic [7:0] op, input logic [31:0] cmd);
    exp_t e;
    e.opcode  = op;
    e.payload = cmd;
    exp_q.push_back(e);
    last_op  = op;
    last_cmd = cmd;
  endtask

  // Scoreboard: every strobe pops one expectation; outputs must hold otherwise.
  always @(negedge clock) begin
    if (!ext_reset_n) begin
      prev_op  = opcode;
      prev_cmd = command;
    end else begin
      if (cmd_error) err_count++;
      if (cmd_recv_rx) begin
        strobes++;
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_strobe: got opcode %0h command %0h, expected no strobe", opcode, command);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if (opcode !== e.opcode || command !== e.payload) begin
            miscompares++;
            $display("FAIL strobe_data: got %0h/%0h expected %0h/%0h", opcode, command, e.opcode, e.payload);
          end
        end
      end else if (opcode !== prev_op || command !== prev_cmd) begin
        miscompares++;
        $display("FAIL hold: outputs changed to %0h/%0h without strobe, expected %0h/%0h",
                 opcode, command, prev_op, prev_cmd);
      end
      prev_op  = opcode;
      prev_cmd = command;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish");
    $fatal(1, "watchdog");
  end

  vec_t vecs[10];

  initial begin
    int strobes0, errs0, waited;
    logic [39:0] bb;

    vecs[0] = '{1, 40'h02,             0, 0, 0, 1, 0, OP_QUERY_ID,   32'h0};
    vecs[1] = '{5, 40'h00_20_00_10_81, 0, 0, 0, 1, 0, OP_SET_COUNT,  32'h0020_0010};
    vecs[2] = '{2, 40'hFF_C0,          0, 1, 0, 0, 1, 8'h00,         32'h0};
    vecs[3] = '{1, 40'h01,             0, 0, 0, 1, 0, OP_ARM,        32'h0};
    vecs[4] = '{5, 40'h7F_81_FF_80_C1, 3, 0, 0, 1, 0, OP_TRIG_VAL,   32'h7F81_FF80};
    vecs[5] = '{0, 40'h0,              0, 1, 0, 0, 0, 8'h00,         32'h0};
    vecs[6] = '{3, 40'h02_01_81,       0, 1, 1, 0, 1, 8'h00,         32'h0};
    vecs[7] = '{5, 40'h12_34_56_78_80, 12, 0, 0, 1, 0, OP_SET_DIV,   32'h1234_5678};
    vecs[8] = '{1, 40'h04,             0, 0, 0, 1, 0, OP_QUERY_META, 32'h0};
    vecs[9] = '{0, 40'h0,              0, 1, 1, 0, 0, 8'h00,         32'h0};

    ext_reset_n = 1'b0;
    rx_data = 8'h00; rx_valid = 1'b0; rx_error = 1'b0;
    idle(3);
    check("rst_opcode",  64'(opcode), 64'h0);
    check("rst_command", 64'(command), 64'h0);
    check("rst_strobe",  64'(cmd_recv_rx), 64'h0);
    check("rst_busy",    64'(cmd_busy), 64'h0);
    check("rst_error",   64'(cmd_error), 64'h0);
    ext_reset_n = 1'b1;
    idle(2);

    // Short command latency: strobe exactly two edges after the byte.
    expect_cmd(OP_QUERY_ID, 32'h0);
    send_byte(OP_QUERY_ID);
    @(negedge clock); check("short_lat1", 64'(cmd_recv_rx), 64'h0);
    check("short_busy", 64'(cmd_busy), 64'h0);
    @(negedge clock); check("short_lat2", 64'(cmd_recv_rx), 64'h1);
    check("short_op", 64'(opcode), 64'h02);
    @(negedge clock); check("short_lat3", 64'(cmd_recv_rx), 64'h0);
    idle(2);

    // Long command busy window.
    send_byte(OP_SET_COUNT);
    @(negedge clock); check("long_busy_start", 64'(cmd_busy), 64'h1);
    send_byte(8'h10); send_byte(8'h00); send_byte(8'h20);
    check("long_busy_mid", 64'(cmd_busy), 64'h1);
    expect_cmd(OP_SET_COUNT, 32'h0020_0010);
    send_byte(8'h00);
    @(negedge clock); check("long_busy_commit", 64'(cmd_busy), 64'h0);
    check("long_no_early_strobe", 64'(cmd_recv_rx), 64'h0);
    @(negedge clock); check("long_strobe", 64'(cmd_recv_rx), 64'h1);
    check("long_cmd", 64'(command), 64'h0020_0010);
    idle(2);

    // Five back-to-back SUMP reset bytes, each after the first lands in COMMIT.
    strobes0 = strobes;
    for (int i = 0; i < 5; i++) expect_cmd(OP_RESET, 32'h0);
    for (int i = 0; i < 5; i++) send_byte(OP_RESET);
    idle(4);
    check("reset5_strobes", 64'(strobes - strobes0), 64'd5);
    check("reset5_queue", 64'(exp_q.size()), 64'd0);

    for (int v = 0; v < 10; v++) begin
      errs0 = err_count;
      bb = vecs[v].bytes;
      for (int i = 0; i < int'(vecs[v].nbytes); i++) begin
        if (vecs[v].exp_strobe && i == int'(vecs[v].nbytes) - 1)
          expect_cmd(vecs[v].exp_op, vecs[v].exp_cmd);
        send_byte(bb[8*i +: 8]);
        if (i != int'(vecs[v].nbytes) - 1) idle(int'(vecs[v].gap));
      end
      if (vecs[v].abort) begin
        rx_error = 1'b1;
        rx_valid = vecs[v].abort_valid;
        rx_data  = OP_QUERY_ID;
        @(posedge clock); #1;
        rx_error = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
      end
      idle(4);
      check($sformatf("vec%0d_queue", v), 64'(exp_q.size()), 64'd0);
      check($sformatf("vec%0d_errors", v), 64'(err_count - errs0), 64'(vecs[v].exp_err));
      check($sformatf("vec%0d_held", v), {24'h0, opcode, command}, {24'h0, last_op, last_cmd});
      check($sformatf("vec%0d_busy", v), 64'(cmd_busy), 64'h0);
    end

    // Reset in the middle of a long command.
    send_byte(OP_SET_DIV); send_byte(8'h11); send_byte(8'h22);
    ext_reset_n = 1'b0;
    #1;
    check("midrst_opcode",  64'(opcode), 64'h0);
    check("midrst_command", 64'(command), 64'h0);
    check("midrst_busy",    64'(cmd_busy), 64'h0);
    check("midrst_strobe",  64'(cmd_recv_rx), 64'h0);
    check("midrst_error",   64'(cmd_error), 64'h0);
    idle(2);
    ext_reset_n = 1'b1;
    idle(1);
    last_op = 8'h00; last_cmd = 32'h0;
    send_byte(OP_SET_DIV); send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC);
    expect_cmd(OP_SET_DIV, 32'hDDCC_BBAA);
    send_byte(8'hDD);
    idle(4);
    check("postrst_queue", 64'(exp_q.size()), 64'd0);
    check("postrst_cmd", {24'h0, opcode, command}, {24'h0, OP_SET_DIV, 32'hDDCC_BBAA});

`ifdef CMD_TIMEOUT_EN
    // Idle past the limit: partial discarded with one error pulse.
    errs0 = err_count;
    send_byte(OP_SET_DIV); send_byte(8'hAA);
    waited = 0;
    while (err_count == errs0 && waited < 40) begin
      idle(1);
      waited++;
    end
    check("timeout_error", 64'(err_count - errs0), 64'd1);
    check("timeout_not_early", 64'(waited >= 16 && waited <= 20), 64'd1);
    check("timeout_busy", 64'(cmd_busy), 64'h0);
    // Fifteen idle cycles is still inside the window.
    errs0 = err_count;
    send_byte(OP_SET_DIV); send_byte(8'hAA);
    idle(15);
    send_byte(8'hBB); send_byte(8'hCC);
    expect_cmd(OP_SET_DIV, 32'hDDCC_BBAA);
    send_byte(8'hDD);
    idle(4);
    check("no_timeout_errors", 64'(err_count - errs0), 64'd0);
    check("no_timeout_queue", 64'(exp_q.size()), 64'd0);
`else
    // Without the timeout a partial command waits indefinitely.
    errs0 = err_count;
    send_byte(OP_SET_DIV); send_byte(8'h01);
    idle(300);
    check("wait_busy", 64'(cmd_busy), 64'h1);
    check("wait_errors", 64'(err_count - errs0), 64'd0);
    send_byte(8'h02); send_byte(8'h03);
    expect_cmd(OP_SET_DIV, 32'h0403_0201);
    send_byte(8'h04);
    idle(4);
    check("wait_queue", 64'(exp_q.size()), 64'd0);
    check("wait_cmd", {24'h0, opcode, command}, {24'h0, OP_SET_DIV, 32'h0403_0201});
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
